// File: rtl/bp_resolve_update_if.sv
// Training-write channel from the resolve stage to the predictor table write port.
// Valid/ready handshake; the master holds the payload stable while stalled.
interface bp_resolve_update_if #(
    parameter int unsigned IDX_BITS = 14
);
    logic                upd_valid;
    logic                upd_ready;
    logic [IDX_BITS-1:0] upd_idx;
    logic                upd_taken;
    logic                upd_mispred;

    modport master (
        output upd_valid,
        output upd_idx,
        output upd_taken,
        output upd_mispred,
        input  upd_ready
    );

    modport slave (
        input  upd_valid,
        input  upd_idx,
        input  upd_taken,
        input  upd_mispred,
        output upd_ready
    );
endinterface

// File: rtl/bp_resolve_update.sv
// Execute-side branch resolution: misprediction redirect, GHR repair, and a small
// FIFO of training writes drained to the predictor table, plus resolution counters.
module bp_resolve_update #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned IDX_BITS = 14,
    parameter int unsigned GHR_BITS = 8,
    parameter int unsigned DEPTH    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ex_branch_valid,
    input  logic                ex_kill,
    input  logic [WIDTH-1:0]    ex_pc,
    input  logic                ex_taken,
    input  logic                ex_pred,
    input  logic [WIDTH-1:0]    ex_target,
    input  logic [WIDTH-1:0]    ex_fallthrough,
    output logic                mispredict,
    output logic [WIDTH-1:0]    redirect_pc,
    output logic                ghr_repair_valid,
    output logic [GHR_BITS-1:0] ghr_repair,
    bp_resolve_update_if.master upd,
    output logic                upd_drop,
    output logic [31:0]         branch_count,
    output logic [31:0]         mispred_count
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned EntW = IDX_BITS + 2;

    logic                res;
    logic                full;
    logic                push;
    logic                pop;
    logic [EntW-1:0]     mem_q [DEPTH];
    logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]     count_q, count_d;
    logic [GHR_BITS-1:0] ghr_q, ghr_d;
    logic                drop_q, drop_d;
    logic [31:0]         br_cnt_q, br_cnt_d;
    logic [31:0]         mp_cnt_q, mp_cnt_d;
    logic                unused_pc_hi;

    assign unused_pc_hi = ^ex_pc[WIDTH-1:IDX_BITS];

    assign res              = ex_branch_valid & ~ex_kill;
    assign mispredict       = res & (ex_taken ^ ex_pred);
    assign redirect_pc      = res ? (ex_taken ? ex_target : ex_fallthrough) : '0;
    assign ghr_repair       = {ghr_q[GHR_BITS-2:0], ex_taken};
    assign ghr_repair_valid = mispredict;

    assign upd.upd_valid = (count_q != '0);
    assign {upd.upd_idx, upd.upd_taken, upd.upd_mispred} = mem_q[rd_ptr_q];
    assign upd_drop      = drop_q;
    assign branch_count  = br_cnt_q;
    assign mispred_count = mp_cnt_q;

    // A pop in the same cycle frees the slot, so a full queue can still accept a push.
    assign full = (count_q == CntW'(DEPTH));
    assign pop  = upd.upd_valid & upd.upd_ready;
    assign push = res & (~full | pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        ghr_d    = ghr_q;
        br_cnt_d = br_cnt_q;
        mp_cnt_d = mp_cnt_q;
        drop_d   = res & full & ~pop;

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase

        if (res) begin
            ghr_d = ghr_repair;
            if (br_cnt_q != '1) begin
                br_cnt_d = br_cnt_q + 32'd1;
            end
        end
        if (mispredict && (mp_cnt_q != '1)) begin
            mp_cnt_d = mp_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ghr_q    <= '0;
            drop_q   <= 1'b0;
            br_cnt_q <= '0;
            mp_cnt_q <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ghr_q    <= ghr_d;
            drop_q   <= drop_d;
            br_cnt_q <= br_cnt_d;
            mp_cnt_q <= mp_cnt_d;
        end
    end

    // Storage is not reset; only the pointers and count define what is live.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_q[wr_ptr_q] <= {ex_pc[IDX_BITS-1:0], ex_taken, mispredict};
        end
    end
endmodule

// File: tb/tb_bp_resolve_update.sv
// Self-checking bench for bp_resolve_update: directed scenarios plus a randomized run,
// with a queue of expected training writes checked as the DUT hands them out.
module tb_bp_resolve_update;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_branch_valid;
    logic        ex_kill;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic        ex_pred;
    logic [31:0] ex_target;
    logic [31:0] ex_fallthrough;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic        ghr_repair_valid;
    logic [7:0]  ghr_repair;
    logic        upd_drop;
    logic [31:0] branch_count;
    logic [31:0] mispred_count;

    bp_resolve_update_if #(.IDX_BITS(14)) upd_bus ();

    bp_resolve_update #(
        .WIDTH    (32),
        .IDX_BITS (14),
        .GHR_BITS (8),
        .DEPTH    (DEPTH)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .ex_branch_valid  (ex_branch_valid),
        .ex_kill          (ex_kill),
        .ex_pc            (ex_pc),
        .ex_taken         (ex_taken),
        .ex_pred          (ex_pred),
        .ex_target        (ex_target),
        .ex_fallthrough   (ex_fallthrough),
        .mispredict       (mispredict),
        .redirect_pc      (redirect_pc),
        .ghr_repair_valid (ghr_repair_valid),
        .ghr_repair       (ghr_repair),
        .upd              (upd_bus),
        .upd_drop         (upd_drop),
        .branch_count     (branch_count),
        .mispred_count    (mispred_count)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    logic [15:0] exp_q [$];
    logic [7:0]  m_ghr  = '0;
    logic [31:0] m_br   = '0;
    logic [31:0] m_mp   = '0;
    logic        m_drop = 1'b0;

    task automatic drive(input logic v, input logic k, input logic [31:0] pc, input logic t,
                         input logic p, input logic [31:0] tgt, input logic [31:0] ft);
        ex_branch_valid = v;
        ex_kill         = k;
        ex_pc           = pc;
        ex_taken        = t;
        ex_pred         = p;
        ex_target       = tgt;
        ex_fallthrough  = ft;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    // One clock: check a handed-out write against the queue front, push the expected
    // entry for this cycle's resolve, advance the reference state, move to the next negedge.
    task automatic step();
        logic r, mp, pop, push;
        #1;
        r   = ex_branch_valid & ~ex_kill;
        mp  = r & (ex_taken ^ ex_pred);
        pop = !rst && (exp_q.size() != 0) && (upd_bus.upd_ready === 1'b1);
        if (pop) begin
            compared++;
            if (upd_bus.upd_valid !== 1'b1 ||
                {upd_bus.upd_idx, upd_bus.upd_taken, upd_bus.upd_mispred} !== exp_q[0]) begin
                mismatched++;
                $display("FAIL sb_pop: got valid=%b entry=%h, required valid=1 entry=%h",
                         upd_bus.upd_valid,
                         {upd_bus.upd_idx, upd_bus.upd_taken, upd_bus.upd_mispred}, exp_q[0]);
            end
            void'(exp_q.pop_front());
        end
        push   = !rst && r && (exp_q.size() < DEPTH);
        m_drop = !rst && r && !push;
        if (push) exp_q.push_back({ex_pc[13:0], ex_taken, mp});
        if (rst) begin
            exp_q.delete();
            m_ghr  = '0;
            m_br   = '0;
            m_mp   = '0;
            m_drop = 1'b0;
        end else if (r) begin
            m_ghr = {m_ghr[6:0], ex_taken};
            if (m_br != 32'hFFFF_FFFF) m_br++;
            if (mp && m_mp != 32'hFFFF_FFFF) m_mp++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        upd_bus.upd_ready = 1'b0;
        idle();
        step();
        step();
        rst = 1'b0;
        #1;
        compared++;
        if (upd_bus.upd_valid !== 1'b0 || upd_drop !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_fifo: got valid=%b drop=%b, required 0 0",
                     upd_bus.upd_valid, upd_drop);
        end
        compared++;
        if (branch_count !== 32'd0 || mispred_count !== 32'd0) begin
            mismatched++;
            $display("FAIL reset_counts: got %0d/%0d, required 0/0", branch_count, mispred_count);
        end
        compared++;
        if (ghr_repair !== 8'h00 || mispredict !== 1'b0 || redirect_pc !== 32'h0) begin
            mismatched++;
            $display("FAIL reset_comb: got ghr=%h misp=%b pc=%h, required 00 0 0",
                     ghr_repair, mispredict, redirect_pc);
        end
    endtask

    task automatic test_correct_pred();
        drive(1'b1, 1'b0, 32'h0000_0040, 1'b1, 1'b1, 32'h0000_0080, 32'h0000_0044);
        #1;
        compared++;
        if (mispredict !== 1'b0 || redirect_pc !== 32'h0000_0080) begin
            mismatched++;
            $display("FAIL correct_comb: got misp=%b pc=%h, required 0 00000080",
                     mispredict, redirect_pc);
        end
        step();
        idle();
        #1;
        compared++;
        if (upd_bus.upd_valid !== 1'b1 || upd_bus.upd_idx !== 14'h0040 ||
            upd_bus.upd_taken !== 1'b1 || upd_bus.upd_mispred !== 1'b0) begin
            mismatched++;
            $display("FAIL correct_upd: got v=%b idx=%h t=%b m=%b, required 1 0040 1 0",
                     upd_bus.upd_valid, upd_bus.upd_idx, upd_bus.upd_taken, upd_bus.upd_mispred);
        end
        compared++;
        if (branch_count !== 32'd1 || mispred_count !== 32'd0) begin
            mismatched++;
            $display("FAIL correct_counts: got %0d/%0d, required 1/0", branch_count, mispred_count);
        end
        upd_bus.upd_ready = 1'b1;
        step();
        compared++;
        if (upd_bus.upd_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL correct_drain: got valid=%b, required 0", upd_bus.upd_valid);
        end
    endtask

    task automatic test_mispredict();
        logic [7:0] pat;
        pat = 8'b1010_1010;
        upd_bus.upd_ready = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            drive(1'b1, 1'b0, 32'h80 + 32'(i * 4), pat[i], pat[i], 32'h0, 32'h0);
            step();
        end
        drive(1'b1, 1'b0, 32'h0000_0100, 1'b0, 1'b1, 32'h0000_00F0, 32'h0000_0104);
        #1;
        compared++;
        if (mispredict !== 1'b1 || ghr_repair_valid !== 1'b1 || redirect_pc !== 32'h0000_0104) begin
            mismatched++;
            $display("FAIL mispred_comb: got misp=%b gv=%b pc=%h, required 1 1 00000104",
                     mispredict, ghr_repair_valid, redirect_pc);
        end
        compared++;
        if (ghr_repair !== 8'b0101_0100) begin
            mismatched++;
            $display("FAIL mispred_ghr: got %b, required 01010100", ghr_repair);
        end
        step();
        idle();
        compared++;
        if (branch_count !== 32'd10 || mispred_count !== 32'd1) begin
            mismatched++;
            $display("FAIL mispred_counts: got %0d/%0d, required 10/1", branch_count, mispred_count);
        end
        step();
        step();
    endtask

    task automatic test_full_backpressure();
        upd_bus.upd_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 1'b0, 32'(i * 4), i[0], 1'b0, 32'h0, 32'h0);
            step();
            if (i == 4) begin
                compared++;
                if (upd_drop !== 1'b0) begin
                    mismatched++;
                    $display("FAIL full_nodrop4: got drop=%b, required 0", upd_drop);
                end
            end
        end
        idle();
        #1;
        compared++;
        if (upd_drop !== 1'b1 || upd_bus.upd_idx !== 14'h0004 || upd_bus.upd_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL full_drop: got drop=%b idx=%h v=%b, required 1 0004 1",
                     upd_drop, upd_bus.upd_idx, upd_bus.upd_valid);
        end
        compared++;
        if (branch_count !== 32'd15 || mispred_count !== 32'd4) begin
            mismatched++;
            $display("FAIL full_counts: got %0d/%0d, required 15/4", branch_count, mispred_count);
        end
        step();
        compared++;
        if (upd_drop !== 1'b0 || upd_bus.upd_idx !== 14'h0004) begin
            mismatched++;
            $display("FAIL full_hold: got drop=%b idx=%h, required 0 0004", upd_drop, upd_bus.upd_idx);
        end
        upd_bus.upd_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        compared++;
        if (upd_bus.upd_valid !== 1'b0 || exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL full_drain: got valid=%b left=%0d, required 0 0",
                     upd_bus.upd_valid, exp_q.size());
        end
    endtask

    task automatic test_push_pop_full();
        upd_bus.upd_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 1'b0, 32'h200 + 32'(i * 4), 1'b1, 1'b1, 32'h0, 32'h0);
            step();
        end
        upd_bus.upd_ready = 1'b1;
        drive(1'b1, 1'b0, 32'h0000_0300, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        upd_bus.upd_ready = 1'b0;
        // Still full after the simultaneous push/pop, so another resolve must drop.
        drive(1'b1, 1'b0, 32'h0000_0400, 1'b1, 1'b0, 32'h0, 32'h0);
        #1;
        compared++;
        if (upd_drop !== 1'b0 || upd_bus.upd_idx !== 14'h0208) begin
            mismatched++;
            $display("FAIL pp_nodrop: got drop=%b idx=%h, required 0 0208",
                     upd_drop, upd_bus.upd_idx);
        end
        step();
        idle();
        compared++;
        if (upd_drop !== 1'b1) begin
            mismatched++;
            $display("FAIL pp_still_full: got drop=%b, required 1", upd_drop);
        end
        upd_bus.upd_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        compared++;
        if (upd_bus.upd_valid !== 1'b0 || branch_count !== m_br || mispred_count !== m_mp) begin
            mismatched++;
            $display("FAIL pp_drain: got v=%b cnt=%0d/%0d, required 0 %0d/%0d",
                     upd_bus.upd_valid, branch_count, mispred_count, m_br, m_mp);
        end
    endtask

    task automatic test_kill();
        upd_bus.upd_ready = 1'b0;
        drive(1'b1, 1'b1, 32'h0000_0500, 1'b1, 1'b0, 32'h0000_0600, 32'h0000_0504);
        #1;
        compared++;
        if (mispredict !== 1'b0 || ghr_repair_valid !== 1'b0 || redirect_pc !== 32'h0) begin
            mismatched++;
            $display("FAIL kill_comb: got misp=%b gv=%b pc=%h, required 0 0 0",
                     mispredict, ghr_repair_valid, redirect_pc);
        end
        step();
        idle();
        #1;
        compared++;
        if (upd_bus.upd_valid !== 1'b0 || branch_count !== m_br || mispred_count !== m_mp ||
            ghr_repair !== {m_ghr[6:0], 1'b0}) begin
            mismatched++;
            $display("FAIL kill_state: got v=%b cnt=%0d/%0d ghr=%h, required 0 %0d/%0d %h",
                     upd_bus.upd_valid, branch_count, mispred_count, ghr_repair,
                     m_br, m_mp, {m_ghr[6:0], 1'b0});
        end
    endtask

    task automatic test_reset_mid_drain();
        upd_bus.upd_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 32'h700 + 32'(i * 4), 1'b1, 1'b0, 32'h0, 32'h0);
            step();
        end
        upd_bus.upd_ready = 1'b1;
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        compared++;
        if (upd_bus.upd_valid !== 1'b0 || branch_count !== 32'd0 || mispred_count !== 32'd0 ||
            ghr_repair !== 8'h00) begin
            mismatched++;
            $display("FAIL rstmid_state: got v=%b cnt=%0d/%0d ghr=%h, required 0 0/0 00",
                     upd_bus.upd_valid, branch_count, mispred_count, ghr_repair);
        end
        upd_bus.upd_ready = 1'b0;
        drive(1'b1, 1'b0, 32'h0000_003C, 1'b1, 1'b1, 32'h0, 32'h0);
        step();
        idle();
        #1;
        compared++;
        if (upd_bus.upd_valid !== 1'b1 || upd_bus.upd_idx !== 14'h003C ||
            branch_count !== 32'd1 || ghr_repair !== 8'b0000_0010) begin
            mismatched++;
            $display("FAIL rstmid_after: got v=%b idx=%h cnt=%0d ghr=%b, required 1 003c 1 00000010",
                     upd_bus.upd_valid, upd_bus.upd_idx, branch_count, ghr_repair);
        end
        upd_bus.upd_ready = 1'b1;
        step();
    endtask

    task automatic test_back_to_back();
        logic        v, k, t, p;
        logic [31:0] pc;
        for (int n = 0; n < 200; n++) begin
            v  = ($urandom_range(0, 3) != 0);
            k  = ($urandom_range(0, 7) == 0);
            t  = 1'($urandom_range(0, 1));
            p  = 1'($urandom_range(0, 1));
            pc = $urandom & 32'hFFFF_FFFC;
            upd_bus.upd_ready = ($urandom_range(0, 2) == 0);
            drive(v, k, pc, t, p, pc + 32'h100, pc + 32'h4);
            #1;
            compared++;
            if (mispredict !== ((v & ~k) & (t ^ p))) begin
                mismatched++;
                $display("FAIL b2b_misp[%0d]: got %b, required %b", n, mispredict,
                         (v & ~k) & (t ^ p));
            end
            step();
            compared++;
            if (upd_drop !== m_drop || branch_count !== m_br || mispred_count !== m_mp ||
                upd_bus.upd_valid !== (exp_q.size() != 0)) begin
                mismatched++;
                $display("FAIL b2b_state[%0d]: got drop=%b cnt=%0d/%0d v=%b, required %b %0d/%0d %b",
                         n, upd_drop, branch_count, mispred_count, upd_bus.upd_valid,
                         m_drop, m_br, m_mp, exp_q.size() != 0);
            end
        end
        idle();
        upd_bus.upd_ready = 1'b1;
        for (int i = 0; i <= DEPTH; i++) step();
        compared++;
        if (upd_bus.upd_valid !== 1'b0 || exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL b2b_drain: got valid=%b left=%0d, required 0 0",
                     upd_bus.upd_valid, exp_q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_correct_pred();
        test_mispredict();
        test_full_backpressure();
        test_push_pop_full();
        test_kill();
        test_reset_mid_drain();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
